// File: rtl/ll_freelist_ctrl.sv
// Free-list manager for the lock-manager node pool: a FIFO of free node indices
// filled at start-up, with round-robin allocation and a single free port.
module ll_freelist_ctrl #(
  parameter int ADDR_W       = 8,
  parameter int NUM_REQ      = 4,
  parameter int RESERVE_ZERO = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [NUM_REQ-1:0] alloc_req,
  output logic [NUM_REQ-1:0] alloc_gnt,
  output logic [ADDR_W-1:0]  alloc_addr,
  input  logic               free_valid,
  input  logic [ADDR_W-1:0]  free_addr,
  output logic               free_ready,
  output logic               init_done,
  output logic [ADDR_W:0]    free_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [ADDR_W:0]   CAP        = (ADDR_W + 1)'(DEPTH - RESERVE_ZERO);
  localparam logic [ADDR_W-1:0] FILL_FIRST = ADDR_W'(RESERVE_ZERO);
  localparam logic [ADDR_W-1:0] FILL_LAST  = {ADDR_W{1'b1}};
  localparam logic [RR_W-1:0]   RR_LAST    = RR_W'(NUM_REQ - 1);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  function automatic logic [RR_W-1:0] rr_next(input logic [RR_W-1:0] idx);
    return (idx == RR_LAST) ? '0 : idx + 1'b1;
  endfunction

  function automatic logic is_null(input logic [ADDR_W-1:0] addr);
    return (RESERVE_ZERO != 0) && (addr == '0);
  endfunction

  state_t            state_q, state_nx;
  logic [ADDR_W-1:0] fill_cnt_q;
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic [RR_W-1:0]   rr_q;
  logic [ADDR_W-1:0] head_p1;
  logic              vld_p1;
  logic [ADDR_W-1:0] mem [DEPTH];

  logic              run;
  logic              fill_en;
  logic              head_ok;
  logic              push;
  logic              pop;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_data;
  logic [RR_W-1:0]   gnt_idx;
  logic [RR_W-1:0]   scan;
  logic              found;

  always_comb begin
    state_nx = state_q;
    fill_en  = 1'b0;
    case (state_q)
      S_INIT: begin
        fill_en = 1'b1;
        if (fill_cnt_q == FILL_LAST) state_nx = S_RUN;
      end
      S_RUN:   state_nx = S_RUN;
      default: state_nx = S_INIT;
    endcase
  end

  assign run        = (state_q == S_RUN);
  assign init_done  = run;
  assign free_cnt   = count_q;
  assign head_ok    = run && vld_p1 && (count_q != '0);
  assign free_ready = run && !clear && (count_q < CAP);
  // A null free completes the handshake but never reaches the FIFO.
  assign push       = free_valid && free_ready && !is_null(free_addr);
  assign wr_en      = !clear && (fill_en || push);
  assign wr_data    = fill_en ? fill_cnt_q : free_addr;

  always_comb begin
    alloc_gnt = '0;
    gnt_idx   = rr_q;
    found     = 1'b0;
    scan      = rr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = rr_next(scan);
      if (!found && alloc_req[scan]) begin
        found   = 1'b1;
        gnt_idx = scan;
      end
    end
    if (found && head_ok && !clear) alloc_gnt[gnt_idx] = 1'b1;
  end

  assign pop        = |alloc_gnt;
  assign alloc_addr = pop ? head_p1 : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_INIT;
      fill_cnt_q <= FILL_FIRST;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rr_q       <= RR_LAST;
      head_p1    <= '0;
      vld_p1     <= 1'b0;
    end else if (clear) begin
      state_q    <= S_INIT;
      fill_cnt_q <= FILL_FIRST;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rr_q       <= RR_LAST;
      head_p1    <= '0;
      vld_p1     <= 1'b0;
    end else begin
      state_q <= state_nx;
      if (fill_en) fill_cnt_q <= fill_cnt_q + 1'b1;
      if (wr_en)   wr_ptr_q   <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        rr_q     <= gnt_idx;
      end
      if (wr_en && !pop)      count_q <= count_q + 1'b1;
      else if (!wr_en && pop) count_q <= count_q - 1'b1;
      // Stage p1: registered head read; valid only if the entry sat still for a full cycle.
      head_p1 <= mem[rd_ptr_q];
      vld_p1  <= run && (count_q != '0) && !pop;
    end
  end

endmodule

// File: tb/tb_ll_freelist_ctrl.sv
// Bench for ll_freelist_ctrl: queue-based model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_ll_freelist_ctrl;

  localparam int AW   = 4;
  localparam int NR   = 4;
  localparam int RZ   = 1;
  localparam int CAPN = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic [NR-1:0] alloc_req;
  logic [NR-1:0] alloc_gnt;
  logic [AW-1:0] alloc_addr;
  logic          free_valid;
  logic [AW-1:0] free_addr;
  logic          free_ready;
  logic          init_done;
  logic [AW:0]   free_cnt;

  ll_freelist_ctrl #(.ADDR_W(AW), .NUM_REQ(NR), .RESERVE_ZERO(RZ)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .alloc_req  (alloc_req),
    .alloc_gnt  (alloc_gnt),
    .alloc_addr (alloc_addr),
    .free_valid (free_valid),
    .free_addr  (free_addr),
    .free_ready (free_ready),
    .init_done  (init_done),
    .free_cnt   (free_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic bit_of(input logic [NR-1:0] v, input int j);
    logic [NR-1:0] t;
    t = v >> j;
    return t[0];
  endfunction

  // Model: the free list is a plain queue of indices.
  int            mq[$];
  bit            m_run;
  int            m_fill, m_rr, m_prev_cnt;
  bit            m_prev_pop, m_prev_run;
  logic [NR-1:0] last_gnt = '0;
  int            g_idx[$], g_addr[$], g_cyc[$];

  task automatic model_reset();
    mq.delete();
    m_run      = 1'b0;
    m_fill     = RZ;
    m_rr       = NR - 1;
    m_prev_cnt = 0;
    m_prev_pop = 1'b0;
    m_prev_run = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    int            cnt, gj, gi;
    bit            head_ok, er;
    logic [NR-1:0] eg;
    if (rst) model_reset();
    cnt     = mq.size();
    head_ok = m_prev_run && (m_prev_cnt >= 1) && !m_prev_pop && (cnt >= 1);
    gj      = -1;
    if (m_run && !clear && head_ok)
      for (int k = 1; k <= NR; k++)
        if (gj < 0 && bit_of(alloc_req, (m_rr + k) % NR)) gj = (m_rr + k) % NR;
    eg = '0;
    if (gj >= 0) eg = NR'(1) << gj;
    er = m_run && !clear && (cnt < CAPN);
    check("gnt", 32'(alloc_gnt), 32'(eg));
    if (gj >= 0) check("alloc_addr", 32'(alloc_addr), mq[0]);
    check("free_ready", 32'(free_ready), 32'(er));
    check("init_done", 32'(init_done), 32'(m_run));
    check("free_cnt", 32'(free_cnt), cnt);
    last_gnt = alloc_gnt;
    if (!rst && alloc_gnt != '0) begin
      gi = -1;
      for (int j = 0; j < NR; j++) if (bit_of(alloc_gnt, j)) gi = j;
      g_idx.push_back(gi);
      g_addr.push_back(int'(alloc_addr));
      g_cyc.push_back(cyc);
    end
    if (!rst) begin
      if (clear) model_reset();
      else begin
        m_prev_cnt = cnt;
        m_prev_pop = (gj >= 0);
        m_prev_run = m_run;
        if (!m_run) begin
          mq.push_back(m_fill);
          if (m_fill == (1 << AW) - 1) m_run = 1'b1;
          m_fill++;
        end else begin
          if (gj >= 0) begin
            void'(mq.pop_front());
            m_rr = gj;
          end
          if (free_valid && er && free_addr != '0) mq.push_back(int'(free_addr));
        end
      end
    end
  end

  // Requesters: each wants a number of nodes and drops its request once served.
  int want[NR];
  int last_free_cyc;

  task automatic tick();
    logic [NR-1:0] r;
    @(posedge clk);
    for (int i = 0; i < NR; i++)
      if (bit_of(last_gnt, i) && want[i] > 0) want[i]--;
    #1;
    r = '0;
    for (int i = 0; i < NR; i++) if (want[i] > 0) r = r | (NR'(1) << i);
    alloc_req = r;
  endtask

  task automatic tick_n();
    tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_grants(input int target, input int budget, input string name);
    for (int n = 0; n < budget && g_addr.size() < target; n++) tick_n();
    check(name, g_addr.size(), target);
  endtask

  task automatic free_one(input int a);
    int n;
    tick();
    free_valid = 1'b1;
    free_addr  = AW'(a);
    n = 0;
    @(negedge clk);
    #1;
    while (!free_ready && n < 20) begin
      tick();
      @(negedge clk);
      #1;
      n++;
    end
    check("free_accept", 32'(free_ready), 1);
    last_free_cyc = cyc;
    tick();
    free_valid = 1'b0;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n, base;
    int rr_exp[5];
    int ex_exp[15];
    rr_exp = '{0, 1, 2, 3, 0};
    ex_exp = '{6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 5, 1, 2, 3, 4};
    rst        = 1'b1;
    clear      = 1'b0;
    alloc_req  = '0;
    free_valid = 1'b0;
    free_addr  = '0;
    for (int i = 0; i < NR; i++) want[i] = 0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_gnt", 32'(alloc_gnt), 0);
    check("rst_addr", 32'(alloc_addr), 0);
    check("rst_ready", 32'(free_ready), 0);
    check("rst_init_done", 32'(init_done), 0);
    check("rst_free_cnt", 32'(free_cnt), 0);

    // Fill after reset release.
    @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    while (!init_done && n < 40) begin tick_n(); n++; end
    check("fill_cycles", n, 15);
    check("fill_free_cnt", 32'(free_cnt), 15);
    check("full_ready", 32'(free_ready), 0);

    // Round-robin with all requesters active.
    base = g_addr.size();
    want[0] = 2; want[1] = 1; want[2] = 1; want[3] = 1;
    wait_grants(base + 5, 40, "rr_grants");
    if (g_addr.size() >= base + 5) begin
      for (int k = 0; k < 5; k++) begin
        check("rr_idx", g_idx[base + k], rr_exp[k]);
        check("rr_addr", g_addr[base + k], k + 1);
      end
      for (int k = 0; k < 4; k++) check("rr_gap", g_cyc[base + k + 1] - g_cyc[base + k], 2);
    end
    tick_n();
    check("rr_free_cnt", 32'(free_cnt), 10);

    // Null free is swallowed; regular frees refill to capacity.
    free_one(0);
    check("null_free_cnt", 32'(free_cnt), 10);
    free_one(5);
    check("free5_cnt", 32'(free_cnt), 11);
    for (int a = 1; a <= 4; a++) free_one(a);
    check("refull_cnt", 32'(free_cnt), 15);
    check("refull_ready", 32'(free_ready), 0);

    // Exhaustion: drain everything with one greedy requester.
    base = g_addr.size();
    want[1] = 20;
    wait_grants(base + 15, 80, "exhaust_grants");
    if (g_addr.size() >= base + 15)
      for (int k = 0; k < 15; k++) check("exhaust_addr", g_addr[base + k], ex_exp[k]);
    repeat (4) tick_n();
    check("empty_free_cnt", 32'(free_cnt), 0);
    check("empty_no_grant", g_addr.size(), base + 15);
    free_one(7);
    wait_grants(base + 16, 10, "refill_grant");
    if (g_addr.size() >= base + 16) begin
      check("refill_addr", g_addr[base + 15], 7);
      check("refill_latency", g_cyc[base + 15] - last_free_cyc, 2);
    end
    want[1] = 0;
    tick_n();

    // Grant and free in the same cycle.
    free_one(9);
    free_one(10);
    free_one(11);
    want[2] = 1;
    tick();
    free_valid = 1'b1;
    free_addr  = 4'd12;
    @(negedge clk);
    #1;
    check("simul_gnt", 32'(alloc_gnt), 4);
    check("simul_addr", 32'(alloc_addr), 9);
    check("simul_ready", 32'(free_ready), 1);
    tick();
    free_valid = 1'b0;
    @(negedge clk);
    #1;
    check("simul_free_cnt", 32'(free_cnt), 3);
    base = g_addr.size();
    want[3] = 3;
    wait_grants(base + 3, 20, "order_grants");
    if (g_addr.size() >= base + 3)
      for (int k = 0; k < 3; k++) check("order_addr", g_addr[base + k], 10 + k);

    // Clear in the middle of allocation traffic.
    for (int a = 3; a <= 6; a++) free_one(a);
    base = g_addr.size();
    want[0] = 10;
    wait_grants(base + 1, 20, "pre_clear_grant");
    if (g_addr.size() >= base + 1) check("pre_clear_addr", g_addr[base], 3);
    tick_n();
    tick();
    clear      = 1'b1;
    free_valid = 1'b1;
    free_addr  = 4'd8;
    @(negedge clk);
    #1;
    check("clear_cycle_gnt", 32'(alloc_gnt), 0);
    check("clear_cycle_ready", 32'(free_ready), 0);
    tick();
    clear      = 1'b0;
    free_valid = 1'b0;
    @(negedge clk);
    #1;
    check("post_clear_init_done", 32'(init_done), 0);
    check("post_clear_gnt", 32'(alloc_gnt), 0);
    check("post_clear_free_cnt", 32'(free_cnt), 0);
    n = 0;
    while (!init_done && n < 40) begin tick_n(); n++; end
    check("refill_cycles", n, 15);
    check("refill_free_cnt", 32'(free_cnt), 15);
    base = g_addr.size();
    wait_grants(base + 1, 10, "post_clear_grant");
    if (g_addr.size() >= base + 1) begin
      check("post_clear_idx", g_idx[base], 0);
      check("post_clear_addr", g_addr[base], 1);
    end
    want[0] = 0;
    tick_n();
    tick_n();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
